// File: rtl/eth_gt_reset_pkg.sv
// Shared state encodings and widths for the GT reset/link-bring-up sequencer.
// Pure declarations: no latency or backpressure of its own.
package eth_gt_reset_pkg;

    typedef enum logic [1:0] {
        G_HOLD      = 2'd0,
        G_WAIT_DONE = 2'd1,
        G_RUN       = 2'd2
    } g_state_t;

    typedef enum logic [1:0] {
        L_OFF       = 2'd0,
        L_WAIT_LOCK = 2'd1,
        L_UP        = 2'd2,
        L_RX_RST    = 2'd3
    } l_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int RETRY_W     = 8;

endpackage

// File: rtl/eth_gt_lane_mon.sv
// Per-lane block-lock debouncer, RX datapath reset retry and escalation; lock to link_up = DEBOUNCE+1 cycles.
// No backpressure; with ETH_GT_RESET_STATS_EN a 16-bit lock-drop counter is added.
module eth_gt_lane_mon
    import eth_gt_reset_pkg::*;
#(
    parameter int DEBOUNCE      = 16,
    parameter int LOCK_TIMEOUT  = 125000,
    parameter int RX_RST_CYCLES = 32,
    parameter int MAX_RETRY     = 7
) (
    input  logic        clk_125mhz_int,
    input  logic        gt_tx_reset,
    input  logic        enable,
    input  logic        block_lock,
    output logic        link_up,
    output logic        rx_datapath_reset,
    output logic        escalate
`ifdef ETH_GT_RESET_STATS_EN
    ,
    output logic [15:0] drop_count
`endif
);

    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int RST_W = $clog2(RX_RST_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RX_RST_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    l_state_t         state;
    logic [DEB_W-1:0] deb_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [RST_W-1:0] rst_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic             lock_lost;
    logic             lock_timeout;
    logic             enter_rst;

    // deb_cnt counts consecutive samples disagreeing with the current lane level
    assign lock_lost    = (state == L_UP) && (deb_cnt == DEB_DONE);
    assign lock_timeout = (state == L_WAIT_LOCK) && (deb_cnt != DEB_DONE) && (to_cnt == TO_LAST);
    assign enter_rst    = enable && (lock_lost || lock_timeout);

    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            state             <= L_OFF;
            link_up           <= 1'b0;
            rx_datapath_reset <= 1'b0;
            escalate          <= 1'b0;
            deb_cnt           <= '0;
            to_cnt            <= '0;
            rst_cnt           <= '0;
            retry_cnt         <= '0;
        end else if (!enable) begin
            state             <= L_OFF;
            link_up           <= 1'b0;
            rx_datapath_reset <= 1'b0;
            escalate          <= 1'b0;
            deb_cnt           <= '0;
            to_cnt            <= '0;
            rst_cnt           <= '0;
            retry_cnt         <= '0;
        end else begin
            escalate <= 1'b0;
            case (state)
                L_OFF: begin
                    state   <= L_WAIT_LOCK;
                    deb_cnt <= '0;
                    to_cnt  <= '0;
                end
                L_WAIT_LOCK: begin
                    if (deb_cnt == DEB_DONE) begin
                        state     <= L_UP;
                        link_up   <= 1'b1;
                        retry_cnt <= '0;
                        deb_cnt   <= '0;
                    end else begin
                        deb_cnt <= block_lock ? deb_cnt + 1'b1 : '0;
                        to_cnt  <= to_cnt + 1'b1;
                    end
                end
                L_UP: begin
                    deb_cnt <= block_lock ? '0 : deb_cnt + 1'b1;
                end
                L_RX_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        rx_datapath_reset <= 1'b0;
                        rst_cnt           <= '0;
                        deb_cnt           <= '0;
                        to_cnt            <= '0;
                        if (retry_cnt == RTY_MAX) begin
                            escalate  <= 1'b1;
                            state     <= L_OFF;
                            retry_cnt <= '0;
                        end else begin
                            state <= L_WAIT_LOCK;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                default: state <= L_OFF;
            endcase
            if (enter_rst) begin
                state             <= L_RX_RST;
                link_up           <= 1'b0;
                rx_datapath_reset <= 1'b1;
                rst_cnt           <= '0;
                deb_cnt           <= '0;
                to_cnt            <= '0;
                if (retry_cnt != RTY_MAX) retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

`ifdef ETH_GT_RESET_STATS_EN
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            drop_count <= '0;
        end else if (enable && lock_lost && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/eth_gt_reset_seq.sv
// GT quad reset and link bring-up sequencer; reset_all drops HOLD_CYCLES+2 after clock_ok, link_up DEBOUNCE+3 after lock.
// Free-running, no backpressure; ETH_GT_RESET_STATS_EN adds per-lane lane_drop_count.
module eth_gt_reset_seq
    import eth_gt_reset_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int HOLD_CYCLES   = 1024,
    parameter int DONE_TIMEOUT  = 1048576,
    parameter int LOCK_TIMEOUT  = 125000,
    parameter int DEBOUNCE      = 16,
    parameter int RX_RST_CYCLES = 32,
    parameter int MAX_RETRY     = 7
) (
    input  logic                 clk_125mhz_int,
    input  logic                 gt_tx_reset,
    input  logic                 clock_ok,
    input  logic                 force_reset,
    input  logic [LANES-1:0]     gt_reset_tx_done,
    input  logic [LANES-1:0]     gt_reset_rx_done,
    input  logic [LANES-1:0]     rx_block_lock,
    output logic                 gtwiz_reset_all,
    output logic [LANES-1:0]     gtwiz_reset_rx_datapath,
    output logic [LANES-1:0]     link_up,
    output logic [1:0]           seq_state,
    output logic [RETRY_W-1:0]   global_retry_count
`ifdef ETH_GT_RESET_STATS_EN
    ,
    output logic [16*LANES-1:0]  lane_drop_count
`endif
);

    localparam int SW     = 1 + 3 * LANES;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DONE_W = $clog2(DONE_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic                           clock_ok_s;
    logic [LANES-1:0]               tx_done_s;
    logic [LANES-1:0]               rx_done_s;
    logic [LANES-1:0]               lock_s;
    logic [LANES-1:0]               escalate;
    logic                           all_done;
    logic                           run_en;
    logic                           reenter_hold;
    g_state_t                       state;
    logic [HOLD_W-1:0]              hold_cnt;
    logic [DONE_W-1:0]              done_cnt;

    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0],
                       {clock_ok, gt_reset_tx_done, gt_reset_rx_done, rx_block_lock}};
        end
    end

    assign {clock_ok_s, tx_done_s, rx_done_s, lock_s} = sync_q[SYNC_STAGES-1];
    assign all_done  = (&tx_done_s) && (&rx_done_s);
    assign run_en    = (state == G_RUN);
    assign seq_state = state;

    // Every cause of a HOLD re-entry in the same cycle collapses into one retry
    assign reenter_hold =
        ((state == G_WAIT_DONE) && !all_done && (done_cnt == DONE_LAST)) ||
        ((state == G_RUN) && (!clock_ok_s || force_reset || !all_done || (|escalate)));

    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            state              <= G_HOLD;
            gtwiz_reset_all    <= 1'b1;
            hold_cnt           <= '0;
            done_cnt           <= '0;
            global_retry_count <= '0;
        end else begin
            case (state)
                G_HOLD: begin
                    if (!clock_ok_s) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state           <= G_WAIT_DONE;
                        gtwiz_reset_all <= 1'b0;
                        hold_cnt        <= '0;
                        done_cnt        <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                G_WAIT_DONE: begin
                    if (all_done) state <= G_RUN;
                    else          done_cnt <= done_cnt + 1'b1;
                end
                G_RUN: ;
                default: state <= G_HOLD;
            endcase
            if (reenter_hold) begin
                state           <= G_HOLD;
                gtwiz_reset_all <= 1'b1;
                hold_cnt        <= '0;
                done_cnt        <= '0;
                if (global_retry_count != '1) global_retry_count <= global_retry_count + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        eth_gt_lane_mon #(
            .DEBOUNCE      (DEBOUNCE),
            .LOCK_TIMEOUT  (LOCK_TIMEOUT),
            .RX_RST_CYCLES (RX_RST_CYCLES),
            .MAX_RETRY     (MAX_RETRY)
        ) u_lane (
            .clk_125mhz_int    (clk_125mhz_int),
            .gt_tx_reset       (gt_tx_reset),
            .enable            (run_en),
            .block_lock        (lock_s[i]),
            .link_up           (link_up[i]),
            .rx_datapath_reset (gtwiz_reset_rx_datapath[i]),
            .escalate          (escalate[i])
`ifdef ETH_GT_RESET_STATS_EN
            ,
            .drop_count        (lane_drop_count[16*i +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_eth_gt_reset_seq.sv
// Directed bench for eth_gt_reset_seq with shrunken timing parameters.
`timescale 1ns/1ps
module tb_eth_gt_reset_seq;

    localparam int LANES = 4;
    localparam int HOLD  = 16;
    localparam int DTO   = 40;
    localparam int LTO   = 30;
    localparam int DEB   = 4;
    localparam int RXR   = 5;
    localparam int MR    = 3;

    logic             clk_125mhz_int = 1'b0;
    logic             gt_tx_reset    = 1'b1;
    logic             clock_ok       = 1'b0;
    logic             force_reset    = 1'b0;
    logic [LANES-1:0] tx_done        = '0;
    logic [LANES-1:0] rx_done        = '0;
    logic [LANES-1:0] lock           = '0;
    logic             gtwiz_reset_all;
    logic [LANES-1:0] rx_rst;
    logic [LANES-1:0] link_up;
    logic [1:0]       seq_state;
    logic [7:0]       grc;
`ifdef ETH_GT_RESET_STATS_EN
    logic [16*LANES-1:0] lane_drop_count;
`endif

    int vectors = 0;
    int errors  = 0;

    always #4 clk_125mhz_int = ~clk_125mhz_int;

    eth_gt_reset_seq #(
        .LANES(LANES), .HOLD_CYCLES(HOLD), .DONE_TIMEOUT(DTO), .LOCK_TIMEOUT(LTO),
        .DEBOUNCE(DEB), .RX_RST_CYCLES(RXR), .MAX_RETRY(MR)
    ) dut (
        .clk_125mhz_int          (clk_125mhz_int),
        .gt_tx_reset             (gt_tx_reset),
        .clock_ok                (clock_ok),
        .force_reset             (force_reset),
        .gt_reset_tx_done        (tx_done),
        .gt_reset_rx_done        (rx_done),
        .rx_block_lock           (lock),
        .gtwiz_reset_all         (gtwiz_reset_all),
        .gtwiz_reset_rx_datapath (rx_rst),
        .link_up                 (link_up),
        .seq_state               (seq_state),
        .global_retry_count      (grc)
`ifdef ETH_GT_RESET_STATS_EN
        ,
        .lane_drop_count         (lane_drop_count)
`endif
    );

    task automatic step();
        @(posedge clk_125mhz_int);
        #1;
    endtask

    task automatic go_run();
        int n;
        n = 0;
        while (!(seq_state === 2'd2 && link_up === 4'hF) && n < 2000) begin
            step();
            n++;
        end
        vectors++;
        if (seq_state !== 2'd2 || link_up !== 4'hF) begin
            errors++;
            $display("FAIL go_run: state=%0d link_up=%b, want state 2 link_up 1111", seq_state, link_up);
        end
    endtask

    task automatic test_reset();
        gt_tx_reset = 1'b1;
        step();
        step();
        vectors++; if (gtwiz_reset_all !== 1'b1) begin errors++; $display("FAIL rst_reset_all: got %b want 1", gtwiz_reset_all); end
        vectors++; if (rx_rst !== 4'h0) begin errors++; $display("FAIL rst_rx_datapath: got %b want 0000", rx_rst); end
        vectors++; if (link_up !== 4'h0) begin errors++; $display("FAIL rst_link_up: got %b want 0000", link_up); end
        vectors++; if (seq_state !== 2'd0) begin errors++; $display("FAIL rst_seq_state: got %0d want 0", seq_state); end
        vectors++; if (grc !== 8'd0) begin errors++; $display("FAIL rst_retry: got %0d want 0", grc); end
    endtask

    task automatic test_bringup();
        int n;
        gt_tx_reset = 1'b0;
        repeat (30) step();
        vectors++; if (gtwiz_reset_all !== 1'b1) begin errors++; $display("FAIL hold_without_clock: got %b want 1", gtwiz_reset_all); end
        clock_ok = 1'b1;
        n = 0;
        do begin step(); n++; end while (gtwiz_reset_all === 1'b1 && n < 200);
        vectors++; if (n != HOLD + 2) begin errors++; $display("FAIL reset_all_fall: after %0d cycles want %0d", n, HOLD + 2); end
        vectors++; if (seq_state !== 2'd1) begin errors++; $display("FAIL wait_done_state: got %0d want 1", seq_state); end
        repeat (10) step();
        tx_done = '1;
        rx_done = '1;
        n = 0;
        do begin step(); n++; end while (seq_state !== 2'd2 && n < 50);
        vectors++; if (n != 3) begin errors++; $display("FAIL run_entry: after %0d cycles want 3", n); end
        step();
        step();
        lock = '1;
        n = 0;
        do begin step(); n++; end while (link_up !== 4'hF && n < 100);
        vectors++; if (n != DEB + 3) begin errors++; $display("FAIL link_up_rise: after %0d cycles want %0d", n, DEB + 3); end
        vectors++; if (rx_rst !== 4'h0) begin errors++; $display("FAIL bringup_rx_rst: got %b want 0000", rx_rst); end
        vectors++; if (grc !== 8'd0) begin errors++; $display("FAIL bringup_retry: got %0d want 0", grc); end
    endtask

    task automatic test_glitch();
        int drops;
        int n;
        int width;
        drops = 0;
        lock[1] = 1'b0;
        repeat (DEB - 1) begin step(); if (link_up[1] !== 1'b1) drops++; end
        lock[1] = 1'b1;
        repeat (12) begin step(); if (link_up[1] !== 1'b1) drops++; end
        vectors++; if (drops != 0) begin errors++; $display("FAIL glitch_filter: link_up[1] low %0d cycles want 0", drops); end
        lock[1] = 1'b0;
        n = 0;
        do begin step(); n++; end while (link_up[1] === 1'b1 && n < 50);
        vectors++; if (n != DEB + 3) begin errors++; $display("FAIL link_up_fall: after %0d cycles want %0d", n, DEB + 3); end
        vectors++; if (link_up !== 4'b1101) begin errors++; $display("FAIL other_lanes_up: got %b want 1101", link_up); end
        vectors++; if (rx_rst !== 4'b0010) begin errors++; $display("FAIL rx_rst_start: got %b want 0010", rx_rst); end
        lock[1] = 1'b1;
        width = 1;
        while (rx_rst[1] === 1'b1 && width < 100) begin
            step();
            if (rx_rst[1] === 1'b1) width++;
        end
        vectors++; if (width != RXR) begin errors++; $display("FAIL rx_rst_width: got %0d cycles want %0d", width, RXR); end
        n = 0;
        while (link_up !== 4'hF && n < 50) begin step(); n++; end
        vectors++; if (link_up !== 4'hF) begin errors++; $display("FAIL lane_recover: got %b want 1111", link_up); end
    endtask

    task automatic test_escalation();
        int   pulses, gap, last_gap, w, wbad, n, last_fall;
        logic prev;
        pulses = 0; gap = 0; last_gap = -1; w = 0; wbad = 0; n = 0; last_fall = -100;
        prev = 1'b0;
        lock[2] = 1'b0;
        while (seq_state === 2'd2 && n < 1000) begin
            step();
            n++;
            if (rx_rst[2] === 1'b1 && prev === 1'b0) begin
                pulses++;
                if (pulses > 1) last_gap = gap;
            end
            if (rx_rst[2] === 1'b1) begin
                gap = 0;
                w++;
            end else begin
                gap++;
                if (prev === 1'b1) begin
                    if (w != RXR) wbad++;
                    w = 0;
                    last_fall = n;
                end
            end
            prev = rx_rst[2];
        end
        vectors++; if (seq_state !== 2'd0) begin errors++; $display("FAIL escalate_state: got %0d want 0", seq_state); end
        vectors++; if (pulses != MR) begin errors++; $display("FAIL escalate_pulses: got %0d want %0d", pulses, MR); end
        vectors++; if (last_gap != LTO) begin errors++; $display("FAIL lock_timeout_gap: got %0d want %0d", last_gap, LTO); end
        vectors++; if (wbad != 0) begin errors++; $display("FAIL escalate_pulse_width: %0d pulses not %0d cycles", wbad, RXR); end
        vectors++; if (n - last_fall != 1) begin errors++; $display("FAIL escalate_latency: got %0d want 1", n - last_fall); end
        vectors++; if (link_up !== 4'b1011) begin errors++; $display("FAIL link_before_clear: got %b want 1011", link_up); end
        vectors++; if (gtwiz_reset_all !== 1'b1) begin errors++; $display("FAIL escalate_reset_all: got %b want 1", gtwiz_reset_all); end
        vectors++; if (grc !== 8'd1) begin errors++; $display("FAIL escalate_retry: got %0d want 1", grc); end
        step();
        vectors++; if (link_up !== 4'h0) begin errors++; $display("FAIL link_clear_after_escalate: got %b want 0000", link_up); end
    endtask

    task automatic test_mid_run_loss();
        int n;
        lock = '1;
        go_run();
        force_reset = 1'b1;
        step();
        force_reset = 1'b0;
        vectors++; if (seq_state !== 2'd0) begin errors++; $display("FAIL force_state: got %0d want 0", seq_state); end
        vectors++; if (link_up !== 4'hF) begin errors++; $display("FAIL force_link_lag: got %b want 1111", link_up); end
        step();
        vectors++; if (link_up !== 4'h0) begin errors++; $display("FAIL force_link_clear: got %b want 0000", link_up); end
        vectors++; if (grc !== 8'd2) begin errors++; $display("FAIL force_retry: got %0d want 2", grc); end
        go_run();
        clock_ok = 1'b0;
        n = 0;
        do begin step(); n++; end while (seq_state === 2'd2 && n < 50);
        vectors++; if (n != 3) begin errors++; $display("FAIL clock_loss_latency: after %0d cycles want 3", n); end
        vectors++; if (link_up !== 4'hF) begin errors++; $display("FAIL clock_loss_link_lag: got %b want 1111", link_up); end
        step();
        vectors++; if (link_up !== 4'h0) begin errors++; $display("FAIL clock_loss_link_clear: got %b want 0000", link_up); end
        vectors++; if (grc !== 8'd3) begin errors++; $display("FAIL clock_loss_retry: got %0d want 3", grc); end
        clock_ok = 1'b1;
        n = 0;
        while (seq_state !== 2'd1 && n < 200) begin step(); n++; end
        vectors++; if (seq_state !== 2'd1) begin errors++; $display("FAIL reach_wait_done: got %0d want 1", seq_state); end
        #2;
        gt_tx_reset = 1'b1;
        #1;
        vectors++; if (gtwiz_reset_all !== 1'b1) begin errors++; $display("FAIL async_reset_all: got %b want 1", gtwiz_reset_all); end
        vectors++; if (seq_state !== 2'd0) begin errors++; $display("FAIL async_seq_state: got %0d want 0", seq_state); end
        vectors++; if (grc !== 8'd0) begin errors++; $display("FAIL async_retry: got %0d want 0", grc); end
        vectors++; if (link_up !== 4'h0 || rx_rst !== 4'h0) begin errors++; $display("FAIL async_lanes: link_up %b rx_rst %b want 0000", link_up, rx_rst); end
    endtask

    task automatic test_done_timeout();
        int   n, w, entries, grc_at100;
        logic [1:0] prev;
        tx_done = '0;
        rx_done = '0;
        lock    = '0;
        clock_ok = 1'b1;
        step();
        gt_tx_reset = 1'b0;
        n = 0;
        while (seq_state !== 2'd1 && n < 200) begin step(); n++; end
        w = 0;
        while (seq_state === 2'd1 && w < 200) begin w++; step(); end
        vectors++; if (w != DTO) begin errors++; $display("FAIL done_timeout_len: got %0d cycles want %0d", w, DTO); end
        vectors++; if (seq_state !== 2'd0 || gtwiz_reset_all !== 1'b1) begin errors++; $display("FAIL done_timeout_hold: state %0d reset_all %b want 0/1", seq_state, gtwiz_reset_all); end
        vectors++; if (grc !== 8'd1) begin errors++; $display("FAIL done_timeout_retry: got %0d want 1", grc); end
        entries = 1;
        grc_at100 = -1;
        n = 0;
        prev = seq_state;
        while (entries < 300 && n < 30000) begin
            step();
            n++;
            if (prev === 2'd1 && seq_state === 2'd0) begin
                entries++;
                if (entries == 100) grc_at100 = grc;
            end
            prev = seq_state;
        end
        vectors++; if (grc_at100 != 100) begin errors++; $display("FAIL retry_count_100: got %0d want 100", grc_at100); end
        vectors++; if (grc !== 8'd255) begin errors++; $display("FAIL retry_saturate: got %0d want 255 after %0d entries", grc, entries); end
    endtask

`ifdef ETH_GT_RESET_STATS_EN
    task automatic test_stats();
        int n;
        gt_tx_reset = 1'b1;
        step();
        clock_ok = 1'b1;
        tx_done  = '1;
        rx_done  = '1;
        lock     = '1;
        gt_tx_reset = 1'b0;
        go_run();
        repeat (3) begin
            lock[0] = 1'b0;
            n = 0;
            while (link_up[0] === 1'b1 && n < 100) begin step(); n++; end
            lock[0] = 1'b1;
            n = 0;
            while (link_up[0] !== 1'b1 && n < 100) begin step(); n++; end
        end
        vectors++; if (lane_drop_count[15:0] !== 16'd3) begin errors++; $display("FAIL drop_count_lane0: got %0d want 3", lane_drop_count[15:0]); end
        vectors++; if (lane_drop_count[63:16] !== 48'd0) begin errors++; $display("FAIL drop_count_others: got %h want 0", lane_drop_count[63:16]); end
    endtask
`endif

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_escalation();
        test_mid_run_loss();
        test_done_timeout();
`ifdef ETH_GT_RESET_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
